posit_multiplier_8bit_pipelined: RTL



---
 rtl/posit_multiplier_8bit_pipelined.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/posit_multiplier_8bit_pipelined.sv
// Three-stage pipelined posit8 (es=0) multiplier with valid/ready flow control.
// Stages: decode both operands, multiply into an extended product, round/encode.
module posit_multiplier_8bit_pipelined #(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_lhs,
  input  logic [7:0]           in_rhs,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_product,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_nar,
  output logic                 out_zero
);

  localparam int unsigned EW = 12;  // {nar, zero, sign, scale[3:0], frac[4:0]}
  localparam int unsigned XW = 14;  // {eposit, guard, sticky}

  // Posit8 -> extended posit; scale is two's complement in -6..6.
  function automatic logic [EW-1:0] decode_posit(input logic [7:0] p);
    logic [7:0]  mag;
    logic [6:0]  m;
    logic [6:0]  sh;
    logic        r0;
    logic        done;
    logic [3:0]  scale;
    int unsigned run;
    mag  = p[7] ? (~p + 8'd1) : p;
    m    = mag[6:0];
    r0   = m[6];
    run  = 0;
    done = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!done) begin
        if (m[i] == r0) run++;
        else done = 1'b1;
      end
    end
    scale = r0 ? 4'(run - 32'd1) : 4'(32'd0 - run);
    sh    = m << (run + 32'd1);
    if (p == 8'h80) return {2'b10, 10'b0};
    if (p == 8'h00) return {2'b01, 10'b0};
    return {2'b00, p[7], scale, sh[6:2]};
  endfunction

  // Extended multiply; scale saturates to +-7, which always encodes to maxpos/minpos.
  function automatic logic [XW-1:0] mul_eposit(input logic [EW-1:0] a, input logic [EW-1:0] b);
    logic [11:0]       sig;
    logic signed [5:0] sc;
    logic [3:0]        scl;
    logic [4:0]        fr;
    logic              g;
    logic              s;
    if (a[11] | b[11]) return {1'b1, 13'b0};
    if (a[10] | b[10]) return {2'b01, 12'b0};
    sig = 12'({6'b0, 1'b1, a[4:0]} * {6'b0, 1'b1, b[4:0]});
    sc  = {{2{a[8]}}, a[8:5]} + {{2{b[8]}}, b[8:5]} + {5'b0, sig[11]};
    if (sig[11]) begin
      fr = sig[10:6]; g = sig[5]; s = |sig[4:0];
    end else begin
      fr = sig[9:5];  g = sig[4]; s = |sig[3:0];
    end
    if (sc > 6'sd7)       scl = 4'h7;
    else if (sc < -6'sd7) scl = 4'h9;
    else                  scl = sc[3:0];
    return {2'b00, a[9] ^ b[9], scl, fr, g, s};
  endfunction

  // Extended posit -> posit8 with round-to-nearest-even; never rounds to zero or NaR.
  function automatic logic [7:0] encode_posit(input logic [EW-1:0] e, input logic g, input logic s);
    logic signed [3:0] sc;
    logic [3:0]        n;
    logic [6:0]        tail;
    logic [6:0]        keep;
    logic [15:0]       v;
    logic [7:0]        mag;
    logic              rb;
    logic              st;
    sc   = e[8:5];
    n    = 4'd0;
    tail = 7'd0;
    v    = 16'd0;
    rb   = 1'b0;
    st   = 1'b0;
    if (e[11]) return 8'h80;
    if (e[10]) return 8'h00;
    if (sc > 4'sd6) begin
      keep = 7'h7F;
    end else if (sc < -4'sd6) begin
      keep = 7'h01;
    end else begin
      if (!sc[3]) begin
        n    = e[8:5] + 4'd1;
        tail = {1'b0, e[4:0], g};
        v    = ~(16'hFFFF >> n) | ({tail, 9'b0} >> n);
      end else begin
        n    = 4'd0 - e[8:5];
        tail = {1'b1, e[4:0], g};
        v    = {tail, 9'b0} >> n;
      end
      keep = v[15:9];
      rb   = v[8];
      st   = (|v[7:0]) | s;
      if (rb & (st | keep[0])) keep = keep + 7'd1;
    end
    mag = {1'b0, keep};
    return e[9] ? (~mag + 8'd1) : mag;
  endfunction

  logic                 v1_q, v2_q, v3_q;
  logic                 v1_d, v2_d, v3_d;
  logic                 adv2, adv3, accept;
  logic [EW-1:0]        lhs_q, rhs_q, lhs_d, rhs_d;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q;
  logic [XW-1:0]        eprod_q, eprod_d;
  logic [7:0]           prod_q, prod_d;
  logic                 nar_q, zero_q, nar_d, zero_d;

  // Handshake and next-state; a stage fills whenever it is empty or draining.
  always_comb begin
    adv3     = v2_q & (~v3_q | out_ready);
    adv2     = v1_q & (~v2_q | adv3);
    in_ready = ~v1_q | adv2;
    accept   = in_valid & in_ready & ~flush;
    v1_d     = 1'b0;
    v2_d     = 1'b0;
    v3_d     = 1'b0;
    if (!flush) begin
      v1_d = accept | (v1_q & ~adv2);
      v2_d = adv2 | (v2_q & ~adv3);
      v3_d = adv3 | (v3_q & ~out_ready);
    end
    lhs_d   = decode_posit(in_lhs);
    rhs_d   = decode_posit(in_rhs);
    eprod_d = mul_eposit(lhs_q, rhs_q);
    prod_d  = encode_posit(eprod_q[13:2], eprod_q[1], eprod_q[0]);
    nar_d   = eprod_q[13];
    zero_d  = eprod_q[12] & ~eprod_q[13];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      tag1_q  <= '0;
      eprod_q <= '0;
      tag2_q  <= '0;
      prod_q  <= '0;
      tag3_q  <= '0;
      nar_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (accept) begin
        lhs_q  <= lhs_d;
        rhs_q  <= rhs_d;
        tag1_q <= in_tag;
      end
      if (adv2) begin
        eprod_q <= eprod_d;
        tag2_q  <= tag1_q;
      end
      if (adv3) begin
        prod_q <= prod_d;
        tag3_q <= tag2_q;
        nar_q  <= nar_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid   = v3_q;
  assign out_product = prod_q;
  assign out_tag     = tag3_q;
  assign out_nar     = nar_q;
  assign out_zero    = zero_q;

endmodule
